// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache onto one burst memory port: reads are collected beat by beat into a line, write lines are sent out as beats.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between the caches instead of always going to the dcache.
`timescale 1ns/1ps
module cache_mem_arbiter #(
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [31:0]       d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [31:0]       bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   localparam int NB    = LINE_W / BEAT_W;
   localparam int KW    = $clog2(NB);
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, DONE} state_t;

   state_t            state, state_nx;
   logic [KW-1:0]     k;
   logic              owner_d;
   logic [31:0]       addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] line_q;
   logic              i_req, d_req, grant, grant_d, tie_to_d;
   logic [31:0]       grant_addr;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};
   assign i_req = i_read;
   assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   // last_d: 1 when the dcache was the most recent grant
   logic last_d;
   assign tie_to_d = ~last_d;

   always_ff @(posedge clk) begin
      if (rst) last_d <= 1'b0;
      else if (grant) last_d <= grant_d;
   end
`else
   assign tie_to_d = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      grant      = 1'b0;
      grant_d    = 1'b0;
      grant_addr = '0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               grant      = 1'b1;
               grant_d    = d_req && (!i_req || tie_to_d);
               grant_addr = grant_d ? d_addr : i_addr;
               // a dcache request with both read and write set is a write
               state_nx   = (grant_d && d_write) ? WR_BURST : RD_ISSUE;
            end
         end
         RD_ISSUE: if (bmem_ready) state_nx = RD_WAIT;
         RD_WAIT:  if (bmem_rvalid && k == K_LAST) state_nx = DONE;
         WR_BURST: if (bmem_ready && k == K_LAST) state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k       <= '0;
         owner_d <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         line_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  owner_d <= grant_d;
                  addr_q  <= {grant_addr[31:OFF_W], {OFF_W{1'b0}}};
                  k       <= '0;
                  if (grant_d && d_write) wdata_q <= d_wdata;
               end
            end
            RD_WAIT: begin
               if (bmem_rvalid) begin
                  line_q[BEAT_W*k +: BEAT_W] <= bmem_rdata;
                  k <= k + 1'b1;
               end
            end
            WR_BURST: if (bmem_ready) k <= k + 1'b1;
            default: ;
         endcase
      end
   end

   // Moore outputs: decoded only from registered state, counter and latches
   assign bmem_read  = (state == RD_ISSUE);
   assign bmem_write = (state == WR_BURST);
   assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
   assign bmem_wdata = bmem_write ? wdata_q[BEAT_W*k +: BEAT_W] : '0;
   assign i_resp     = (state == DONE) && !owner_d;
   assign d_resp     = (state == DONE) && owner_d;
   assign i_rdata    = line_q;
   assign d_rdata    = line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: cycle vector tables for the basic bursts plus a responding memory model and a response scoreboard.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;
   localparam int NB = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       i_addr, d_addr, bmem_addr;
   logic              i_read, i_resp, d_read, d_write, d_resp;
   logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
   logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid;
   logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
      .bmem_rvalid(bmem_rvalid)
   );

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [63:0] rd;
      logic        e_read;
      logic        e_write;
      logic [31:0] e_addr;
      logic [63:0] e_wdata;
      logic        e_ir;
      logic        e_dr;
   } vec_t;

   typedef struct {
      logic         owner_d;
      logic [255:0] line;
   } sb_t;

   vec_t         vq[$];
   sb_t          sb[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           got_resp = 0;
   int           rd_cnt = 0;
   int           wr_cnt = 0;
   logic         stall = 1'b0;
   logic [255:0] exp_wline = '0;
   logic [31:0]  exp_waddr = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mkbeat(input logic [31:0] a, input int j);
      return {a, 32'hB0B0_0000 | 32'(j)};
   endfunction

   function automatic logic [255:0] mkline(input logic [31:0] a);
      logic [255:0] l;
      for (int j = 0; j < NB; j++) l[64*j +: 64] = mkbeat(a, j);
      return l;
   endfunction

   function automatic vec_t mkv(input logic rdy, input logic rv, input logic [63:0] rd,
                                input logic er, input logic ew, input logic [31:0] ea,
                                input logic [63:0] ewd, input logic eir, input logic edr);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rd = rd; v.e_read = er; v.e_write = ew;
      v.e_addr = ea; v.e_wdata = ewd; v.e_ir = eir; v.e_dr = edr;
      return v;
   endfunction

   function automatic sb_t mksb(input logic od, input logic [255:0] l);
      sb_t s;
      s.owner_d = od; s.line = l;
      return s;
   endfunction

   // pops the scoreboard on any response and releases the served requester
   task automatic monitor();
      sb_t e;
      if (i_resp || d_resp) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", {i_resp, d_resp}, 2'b00);
         end else begin
            e = sb.pop_front();
            chk("resp_owner", {i_resp, d_resp}, e.owner_d ? 2'b01 : 2'b10);
            chk("resp_line", e.owner_d ? d_rdata : i_rdata, e.line);
         end
         if (i_resp) i_read = 1'b0;
         if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
         got_resp++;
      end
   endtask

   task automatic step(input logic rdy, input logic rv, input logic [63:0] rd);
      bmem_ready = rdy; bmem_rvalid = rv; bmem_rdata = rd;
      monitor();
      @(posedge clk); #1;
   endtask

   task automatic run_vecs(input string tag);
      foreach (vq[i]) begin
         chk($sformatf("%s[%0d].read", tag, i), bmem_read, vq[i].e_read);
         chk($sformatf("%s[%0d].write", tag, i), bmem_write, vq[i].e_write);
         if (vq[i].e_read || vq[i].e_write)
            chk($sformatf("%s[%0d].addr", tag, i), bmem_addr, vq[i].e_addr);
         if (vq[i].e_write)
            chk($sformatf("%s[%0d].wdata", tag, i), bmem_wdata, vq[i].e_wdata);
         chk($sformatf("%s[%0d].i_resp", tag, i), i_resp, vq[i].e_ir);
         chk($sformatf("%s[%0d].d_resp", tag, i), d_resp, vq[i].e_dr);
         step(vq[i].rdy, vq[i].rv, vq[i].rd);
      end
      vq.delete();
   endtask

   // memory model: accepts commands, returns 4 beats after each accepted read
   task automatic run_auto(input int n, input int budget, input string tag);
      int got0 = got_resp;
      int cyc = 0;
      int left = 0;
      int idx = 0;
      logic [31:0] ra = '0;
      while ((got_resp - got0) < n && cyc < budget) begin
         bmem_ready = stall ? ((cyc % 3) != 2) : 1'b1;
         if (left > 0) begin
            bmem_rvalid = 1'b1; bmem_rdata = mkbeat(ra, idx); idx++; left--;
         end else begin
            bmem_rvalid = 1'b0; bmem_rdata = '0;
         end
         if (bmem_read && bmem_ready) begin
            rd_cnt++; ra = bmem_addr; left = NB; idx = 0;
         end
         if (bmem_write && bmem_ready) begin
            chk({tag, ".waddr"}, bmem_addr, exp_waddr);
            chk({tag, ".wbeat"}, bmem_wdata, exp_wline[64*(wr_cnt % 4) +: 64]);
            wr_cnt++;
         end
         monitor();
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, ".resp_count"}, got_resp - got0, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [255:0] l1, wl;
      rst = 1'b1; i_addr = '0; i_read = 0; d_addr = '0; d_read = 0; d_write = 0; d_wdata = '0;
      bmem_ready = 0; bmem_rvalid = 0; bmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.bmem_read", bmem_read, 1'b0);
      chk("rst.bmem_write", bmem_write, 1'b0);
      chk("rst.bmem_addr", bmem_addr, 32'h0);
      chk("rst.bmem_wdata", bmem_wdata, 64'h0);
      chk("rst.i_resp", i_resp, 1'b0);
      chk("rst.d_resp", d_resp, 1'b0);
      chk("rst.i_rdata", i_rdata, 256'h0);
      chk("rst.d_rdata", d_rdata, 256'h0);
      rst = 1'b0;

      // icache read with minimum latency
      l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      i_addr = 32'h6000_0044; i_read = 1'b1;
      sb.push_back(mksb(1'b0, l1));
      vq.push_back(mkv(1, 0, 64'h0, 0, 0, 32'h0, 64'h0, 0, 0));
      vq.push_back(mkv(1, 0, 64'h0, 1, 0, 32'h6000_0040, 64'h0, 0, 0));
      for (int j = 0; j < NB; j++)
         vq.push_back(mkv(1, 1, l1[64*j +: 64], 0, 0, 32'h0, 64'h0, 0, 0));
      vq.push_back(mkv(1, 0, 64'h0, 0, 0, 32'h0, 64'h0, 1, 0));
      run_vecs("rd");

      // dcache write with one stall; stray rvalid in IDLE and WR_BURST must not touch the line buffer
      wl = {64'h0F0F_F0F0_3C3C_C3C3, 64'hA5A5_A5A5_5A5A_5A5A,
            64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
      d_addr = 32'h1000_0000; d_wdata = wl; d_write = 1'b1;
      sb.push_back(mksb(1'b1, l1));
      vq.push_back(mkv(1, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 32'h0, 64'h0, 0, 0));
      vq.push_back(mkv(1, 0, 64'h0, 0, 1, 32'h1000_0000, wl[63:0], 0, 0));
      vq.push_back(mkv(0, 0, 64'h0, 0, 1, 32'h1000_0000, wl[127:64], 0, 0));
      vq.push_back(mkv(1, 1, 64'hBAD0_BAD0_BAD0_BAD0, 0, 1, 32'h1000_0000, wl[127:64], 0, 0));
      vq.push_back(mkv(1, 0, 64'h0, 0, 1, 32'h1000_0000, wl[191:128], 0, 0));
      vq.push_back(mkv(1, 0, 64'h0, 0, 1, 32'h1000_0000, wl[255:192], 0, 0));
      vq.push_back(mkv(1, 0, 64'h0, 0, 0, 32'h0, 64'h0, 0, 1));
      run_vecs("wr");

      // simultaneous reads, fresh arbiter state so the pointer starts at icache
      rst = 1'b1;
      step(0, 0, 64'h0);
      rst = 1'b0;
      i_addr = 32'h3000_0020; i_read = 1'b1;
      d_addr = 32'h2000_0000; d_read = 1'b1;
      sb.push_back(mksb(1'b1, mkline(32'h2000_0000)));
      run_auto(1, 40, "tie1");
      d_addr = 32'h2000_0100; d_read = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      sb.push_back(mksb(1'b0, mkline(32'h3000_0020)));
      run_auto(1, 40, "tie2");
      sb.push_back(mksb(1'b1, mkline(32'h2000_0100)));
      run_auto(1, 40, "tie3");
`else
      sb.push_back(mksb(1'b1, mkline(32'h2000_0100)));
      run_auto(1, 40, "tie2");
      sb.push_back(mksb(1'b0, mkline(32'h3000_0020)));
      run_auto(1, 40, "tie3");
`endif

      // reset in the middle of a read burst after two beats
      i_addr = 32'h4000_0000; i_read = 1'b1;
      step(1, 0, 64'h0);
      chk("abort.issue", bmem_read, 1'b1);
      step(1, 0, 64'h0);
      step(1, 1, 64'hCAFE_0000_CAFE_0000);
      step(1, 1, 64'hCAFE_0001_CAFE_0001);
      rst = 1'b1;
      step(1, 0, 64'h0);
      rst = 1'b0;
      chk("abort.bmem_read", bmem_read, 1'b0);
      chk("abort.bmem_write", bmem_write, 1'b0);
      chk("abort.bmem_addr", bmem_addr, 32'h0);
      chk("abort.i_resp", i_resp, 1'b0);
      chk("abort.d_resp", d_resp, 1'b0);
      chk("abort.i_rdata", i_rdata, 256'h0);
      sb.push_back(mksb(1'b0, mkline(32'h4000_0000)));
      run_auto(1, 40, "post_rst");

      // read and write together: write wins, no read command
      wl = {64'h7777_0003_7777_0003, 64'h7777_0002_7777_0002,
            64'h7777_0001_7777_0001, 64'h7777_0000_7777_0000};
      d_addr = 32'h5000_001F; d_wdata = wl; d_read = 1'b1; d_write = 1'b1;
      exp_wline = wl; exp_waddr = 32'h5000_0000;
      rd_cnt = 0; wr_cnt = 0; stall = 1'b1;
      sb.push_back(mksb(1'b1, mkline(32'h4000_0000)));
      run_auto(1, 60, "rw");
      stall = 1'b0;
      chk("rw.read_cmds", rd_cnt, 0);
      chk("rw.write_beats", wr_cnt, 4);
      chk("sb.drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
